// File: rtl/alu_control_mc.sv
// ALU control decoder with registered result and iterative shift-add multiply.
// Valid/ready handshake on both the request and result sides.
module alu_control_mc #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6,
  parameter int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [FUNC_W-1:0] FuncCode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              err,
  output logic [3:0]        ALUCtl
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  localparam logic [3:0] C_AND = 4'd0;
  localparam logic [3:0] C_OR  = 4'd1;
  localparam logic [3:0] C_ADD = 4'd2;
  localparam logic [3:0] C_MUL = 4'd3;
  localparam logic [3:0] C_SUB = 4'd6;
  localparam logic [3:0] C_SLT = 4'd7;
  localparam logic [3:0] C_NOR = 4'd12;
  localparam logic [3:0] C_ILL = 4'd15;

  localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(32);
  localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(34);
  localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(36);
  localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(37);
  localparam logic [FUNC_W-1:0] F_NOR = FUNC_W'(39);
  localparam logic [FUNC_W-1:0] F_SLT = FUNC_W'(42);
  localparam logic [FUNC_W-1:0] F_MUL = FUNC_W'(24);

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               err_q;
  logic [3:0]         ctl_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [3:0]         ctl_d;
  logic [WIDTH-1:0]   alu_d;
  logic               err_d;
  logic               slt_d;
  logic [WIDTH-1:0]   sum_d;

  always_comb begin
    ctl_d = C_ILL;
    unique case (ALUOp)
      2'b00: ctl_d = C_ADD;
      2'b01: ctl_d = C_SUB;
      2'b10: begin
        case (FuncCode)
          F_ADD:   ctl_d = C_ADD;
          F_SUB:   ctl_d = C_SUB;
          F_AND:   ctl_d = C_AND;
          F_OR:    ctl_d = C_OR;
          F_NOR:   ctl_d = C_NOR;
          F_SLT:   ctl_d = C_SLT;
          F_MUL:   ctl_d = C_MUL;
          default: ctl_d = C_ILL;
        endcase
      end
      default: ctl_d = C_ILL;
    endcase
  end

  always_comb begin
    slt_d = $signed(a) < $signed(b);
    alu_d = '0;
    err_d = 1'b0;
    case (ctl_d)
      C_ADD:   alu_d = a + b;
      C_SUB:   alu_d = a - b;
      C_AND:   alu_d = a & b;
      C_OR:    alu_d = a | b;
      C_NOR:   alu_d = ~(a | b);
      C_SLT:   alu_d = {{(WIDTH-1){1'b0}}, slt_d};
      C_MUL:   alu_d = '0;
      default: err_d = 1'b1;
    endcase
  end

  // One partial-product step; the final step's sum is the result.
  assign sum_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      ctl_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            ctl_q      <= ctl_d;
            in_ready_q <= 1'b0;
            if (ctl_d == C_MUL) begin
              mcand_q  <= a;
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= CNT_W'(WIDTH);
              err_q    <= 1'b0;
              state_q  <= S_MUL;
            end else begin
              result_q    <= alu_d;
              zero_q      <= (alu_d == '0);
              err_q       <= err_d;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q    <= sum_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_q    <= sum_d;
            zero_q      <= (sum_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign ALUCtl    = ctl_q;

endmodule

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
- Parametrised successor to the combinational ALU control decoder. Decodes ALUOp/FuncCode into the 4-bit ALU control code, executes the operation on WIDTH-bit operands, and returns a registered result.
- Adds an iterative shift-add multiply.
- Sits between the multicycle datapath controller and the register-writeback path. Uses a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- FUNC_W, 6, FuncCode width in bits.
- CNT_W, $clog2(WIDTH+1), multiply iteration counter width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- ALUOp  in  2  00=add, 01=sub, 10=decode FuncCode, 11=illegal
- FuncCode  in  FUNC_W  R-type function field
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- zero  out  1  result==0
- err  out  1  illegal operation
- ALUCtl  out  4  decoded control code, registered with result

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Decode when ALUOp=10:
  - FuncCode 32 -> 2 (add)
  - 34 -> 6 (sub)
  - 36 -> 0 (and)
  - 37 -> 1 (or)
  - 39 -> 12 (nor)
  - 42 -> 7 (slt)
  - 24 -> 3 (mul, new)
  - any other value -> 15 (illegal)
- Decode for other ALUOp values: ALUOp=00 -> 2; ALUOp=01 -> 6; ALUOp=11 -> 15.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no overflow flag.
  - slt is a signed two's-complement compare; result is 1 or 0, zero-extended.
  - nor = ~(a|b).
  - mul returns the low WIDTH bits of the unsigned product; these equal the signed low bits.
  - Illegal operation: result=0, err=1.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid at edge e0, ALUCtl is latched.
    - Single-cycle op or illegal: result, zero and err are registered at e0; next state DONE.
    - mul: load mcand=a, mplier=b, acc=0, cnt=WIDTH; next state MUL.
  - MUL: in_ready=0. Each edge:
    - if mplier[0], acc+=mcand;
    - mcand<<=1; mplier>>=1; cnt-=1;
    - when cnt==1, write acc (including this edge's add) to result, compute zero, go to DONE.
  - DONE: out_valid=1, in_ready=0.
    - result, zero, err and ALUCtl are held stable until out_ready.
    - The edge where out_valid&&out_ready is true -> IDLE.
- Latency, counted from the accept edge to the first cycle out_valid=1:
  - single-cycle and illegal ops: 1 cycle.
  - mul: WIDTH+1 cycles.
  - Throughput: at most one request per 2 cycles; no accept while in DONE.
- Input sampling: inputs are sampled only at the accept edge. Changes on a/b/FuncCode during MUL or DONE have no effect.
- Back-pressure: out_ready low holds DONE indefinitely with all outputs unchanged.
- Reset values: reset in any state, including mid-MUL, forces IDLE on that edge. Outputs after reset:
  - out_valid=0, in_ready=1
  - result=0, zero=0, err=0, ALUCtl=0
  - acc, mcand, mplier and cnt cleared.
  - A partial product is discarded; no output is produced for the aborted request.
- in_valid while busy: in_valid asserted outside IDLE is ignored; the requester must hold it until in_ready.
- mul boundary cases: operand 0 yields result 0 and zero=1 after the full WIDTH iterations (no early exit). a=b=all-ones yields result 1.

Test Plan:
- Add, WIDTH=32: ALUOp=10, FuncCode=32, a=5, b=7, out_ready=1 -> result=12, zero=0, ALUCtl=2, out_valid exactly 1 cycle after accept, in_ready back high the next cycle.
- Branch compare: ALUOp=01, a=b=0x1234 -> result=0, zero=1, ALUCtl=6. Then slt with a=0xFFFFFFFF, b=1 -> result=1, ALUCtl=7.
- Multiply: FuncCode=24, a=7, b=6 -> result=42, ALUCtl=3, out_valid first high 33 cycles after accept. a=b=0xFFFFFFFF -> result=1. a=0 -> result=0, zero=1.
- Illegal: FuncCode=0 with ALUOp=10, and separately ALUOp=11 -> result=0, err=1, ALUCtl=15, latency 1.
- Back-pressure: out_ready=0 for 10 cycles after an or (a=0xF0, b=0x0F) -> outputs hold result=0xFF with out_valid=1 and in_ready=0; new in_valid ignored; release -> IDLE next cycle.
- Reset mid-mul: assert reset 10 cycles into a multiply -> next cycle out_valid=0, in_ready=1, result=0. A subsequent add (3+4) returns 7 with no stale product.
